if_id_skid_reg: RTL and testbench



---
 rtl/if_id_pkg.sv | 22 ++
 rtl/if_id_entry.sv | 44 ++++
 rtl/if_id_skid_reg_chk.sv | 29 ++
 rtl/if_id_skid_reg.sv | 142 ++++++++++++++
 tb/tb_if_id_skid_reg.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/if_id_pkg.sv
// Shared types and helpers for the IF->ID skid register: default bundle layout,
// the NOP used for killed lanes, and the lane bit-offset helper.
package if_id_pkg;

   localparam int unsigned XLEN_DEF  = 32;
   localparam int unsigned ILEN_DEF  = 32;
   localparam int unsigned LANES_DEF = 5;

   // addi x0,x0,0
   localparam logic [31:0] NOP_WORD = 32'h0000_0013;

   typedef struct packed {
      logic [XLEN_DEF-1:0]           pc;
      logic [LANES_DEF*ILEN_DEF-1:0] idata;
      logic [LANES_DEF-1:0]          lane_mask;
   } bundle_t;

   function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned ilen);
      return lane * ilen;
   endfunction

endpackage

// File: rtl/if_id_entry.sv
// One pipeline slot: a valid bit plus a bundle payload.
// The payload only changes on load; clear drops valid and leaves the data stale.
module if_id_entry #(
   parameter type T = if_id_pkg::bundle_t
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic load_i,
   input  T     d_i,
   output logic valid_o,
   output T     q_o
);

   logic valid_q, valid_d;
   T     data_q, data_d;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (clr_i) begin
         valid_d = 1'b0;
      end else if (load_i) begin
         valid_d = 1'b1;
         data_d  = d_i;
      end else begin
         valid_d = valid_q;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_q <= 1'b0;
         data_q  <= {$bits(T){1'b0}};
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign valid_o = valid_q;
   assign q_o     = data_q;

endmodule

// File: rtl/if_id_skid_reg_chk.sv
// Structural invariants of the IF->ID skid register: the skid slot is only
// occupied behind a full main slot, and a stalled output holds still.
module if_id_skid_reg_chk #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned IW    = 160,
   parameter int unsigned LANES = 5
) (
   input logic             clk_i,
   input logic             rst_i,
   input logic             flush_i,
   input logic             m_valid_i,
   input logic             s_valid_i,
   input logic             dn_valid_i,
   input logic             dn_ready_i,
   input logic [XLEN-1:0]  dn_pc_i,
   input logic [IW-1:0]    dn_idata_i,
   input logic [LANES-1:0] dn_lane_mask_i
);

   a_skid_implies_main: assert property (@(posedge clk_i) disable iff (rst_i)
      s_valid_i |-> m_valid_i)
      else $error("skid entry valid while main entry empty");

   a_stall_stable: assert property (@(posedge clk_i) disable iff (rst_i)
      (dn_valid_i && !dn_ready_i && !flush_i) |=>
         (dn_valid_i && $stable(dn_pc_i) && $stable(dn_idata_i) && $stable(dn_lane_mask_i)))
      else $error("downstream bundle changed while stalled");

endmodule

// File: rtl/if_id_skid_reg.sv
// IF->ID pipeline register with valid/ready handshake, 2-entry skid (main M + skid S),
// flush, per-lane kill to NOP and a saturating downstream bubble counter.
module if_id_skid_reg
   import if_id_pkg::*;
#(
   parameter int unsigned      XLEN     = 32,
   parameter int unsigned      ILEN     = 32,
   parameter int unsigned      LANES    = 5,
   parameter logic [ILEN-1:0]  NOP_WORD = if_id_pkg::NOP_WORD,
   parameter int unsigned      CNT_W    = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    flush,
   input  logic                    up_valid,
   output logic                    up_ready,
   input  logic [XLEN-1:0]         up_pc,
   input  logic [LANES*ILEN-1:0]   up_idata,
   input  logic [LANES-1:0]        up_lane_mask,
   output logic                    dn_valid,
   input  logic                    dn_ready,
   output logic [XLEN-1:0]         dn_pc,
   output logic [LANES*ILEN-1:0]   dn_idata,
   output logic [LANES-1:0]        dn_lane_mask,
   output logic [CNT_W-1:0]        bubble_cnt
);

   typedef struct packed {
      logic [XLEN-1:0]       pc;
      logic [LANES*ILEN-1:0] idata;
      logic [LANES-1:0]      lane_mask;
   } entry_t;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic                  m_valid_s, s_valid_s;
   entry_t                m_q_s, s_q_s, cap_s, m_d_s;
   logic [LANES*ILEN-1:0] cap_idata_s;
   logic                  accept_s, emit_s;
   logic                  m_load_s, m_clr_s, m_from_skid_s, s_load_s, s_clr_s;
   logic [CNT_W-1:0]      bubble_q, bubble_d;

   // Killed lanes are replaced at capture so decode never sees their stale words.
   for (genvar i = 0; i < LANES; i++) begin : g_lane
      localparam int unsigned LSB = lane_lsb(i, ILEN);
      assign cap_idata_s[LSB +: ILEN] = up_lane_mask[i] ? up_idata[LSB +: ILEN] : NOP_WORD;
   end

   assign cap_s.pc        = up_pc;
   assign cap_s.idata     = cap_idata_s;
   assign cap_s.lane_mask = up_lane_mask;

   assign accept_s = up_valid & ~s_valid_s & ~flush;
   assign emit_s   = m_valid_s & dn_ready;

   always_comb begin
      m_load_s      = 1'b0;
      m_clr_s       = 1'b0;
      m_from_skid_s = 1'b0;
      s_load_s      = 1'b0;
      s_clr_s       = 1'b0;
      if (flush) begin
         m_clr_s = 1'b1;
         s_clr_s = 1'b1;
      end else if (!m_valid_s) begin
         m_load_s = accept_s;
      end else if (emit_s) begin
         if (s_valid_s) begin
            // up_ready was low, so nothing new can arrive while S drains into M
            m_load_s      = 1'b1;
            m_from_skid_s = 1'b1;
            s_clr_s       = 1'b1;
         end else if (accept_s) begin
            m_load_s = 1'b1;
         end else begin
            m_clr_s = 1'b1;
         end
      end else begin
         s_load_s = accept_s;
      end
   end

   assign m_d_s = m_from_skid_s ? s_q_s : cap_s;

   if_id_entry #(.T(entry_t)) u_main (
      .clk_i   (clk),
      .rst_i   (rst),
      .clr_i   (m_clr_s),
      .load_i  (m_load_s),
      .d_i     (m_d_s),
      .valid_o (m_valid_s),
      .q_o     (m_q_s)
   );

   if_id_entry #(.T(entry_t)) u_skid (
      .clk_i   (clk),
      .rst_i   (rst),
      .clr_i   (s_clr_s),
      .load_i  (s_load_s),
      .d_i     (cap_s),
      .valid_o (s_valid_s),
      .q_o     (s_q_s)
   );

   always_comb begin
      bubble_d = bubble_q;
      if (dn_ready && !m_valid_s && (bubble_q != CNT_MAX)) begin
         bubble_d = bubble_q + CNT_W'(1);
      end else begin
         bubble_d = bubble_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bubble_q <= {CNT_W{1'b0}};
      end else begin
         bubble_q <= bubble_d;
      end
   end

   assign up_ready     = ~s_valid_s;
   assign dn_valid     = m_valid_s;
   assign dn_pc        = m_q_s.pc;
   assign dn_idata     = m_q_s.idata;
   assign dn_lane_mask = m_q_s.lane_mask;
   assign bubble_cnt   = bubble_q;

   if_id_skid_reg_chk #(.XLEN(XLEN), .IW(LANES*ILEN), .LANES(LANES)) u_chk (
      .clk_i          (clk),
      .rst_i          (rst),
      .flush_i        (flush),
      .m_valid_i      (m_valid_s),
      .s_valid_i      (s_valid_s),
      .dn_valid_i     (dn_valid),
      .dn_ready_i     (dn_ready),
      .dn_pc_i        (dn_pc),
      .dn_idata_i     (dn_idata),
      .dn_lane_mask_i (dn_lane_mask)
   );

endmodule

// File: tb/tb_if_id_skid_reg.sv
// Bench for if_id_skid_reg: a queue-based reference model of the two-deep stage,
// directed scenarios with literal expectations, then randomized traffic.
module tb_if_id_skid_reg;

   localparam int XLEN  = 32;
   localparam int ILEN  = 32;
   localparam int LANES = 5;
   localparam int CNT_W = 4;
   localparam int IW    = LANES * ILEN;

   logic             clk = 1'b0;
   logic             rst, flush, up_valid, up_ready, dn_valid, dn_ready;
   logic [XLEN-1:0]  up_pc, dn_pc;
   logic [IW-1:0]    up_idata, dn_idata;
   logic [LANES-1:0] up_lane_mask, dn_lane_mask;
   logic [CNT_W-1:0] bubble_cnt;

   always #5 clk = ~clk;

   if_id_skid_reg #(
      .XLEN(XLEN), .ILEN(ILEN), .LANES(LANES), .NOP_WORD(32'h0000_0013), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .up_valid(up_valid), .up_ready(up_ready), .up_pc(up_pc),
      .up_idata(up_idata), .up_lane_mask(up_lane_mask),
      .dn_valid(dn_valid), .dn_ready(dn_ready), .dn_pc(dn_pc),
      .dn_idata(dn_idata), .dn_lane_mask(dn_lane_mask), .bubble_cnt(bubble_cnt)
   );

   typedef struct {
      logic [XLEN-1:0]  pc;
      logic [IW-1:0]    idata;
      logic [LANES-1:0] mask;
   } bund_t;

   bund_t exp_q[$];
   int    exp_cnt = 0;
   int    checks = 0;
   int    failures = 0;
   bit    chk_en = 1'b0;

   task automatic check(input string nm, input logic [IW-1:0] act, input logic [IW-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic bund_t capture(input logic [XLEN-1:0] pc, input logic [IW-1:0] d,
                                     input logic [LANES-1:0] m);
      bund_t b;
      b.pc   = pc;
      b.mask = m;
      for (int i = 0; i < LANES; i++)
         b.idata[i*ILEN +: ILEN] = m[i] ? d[i*ILEN +: ILEN] : 32'h0000_0013;
      return b;
   endfunction

   // Reference model: the stage is a FIFO of at most two bundles.
   always @(posedge clk) begin
      bit can_take;
      if (rst) begin
         exp_q.delete();
         exp_cnt = 0;
      end else begin
         if (dn_ready && exp_q.size() == 0 && exp_cnt < (1 << CNT_W) - 1) exp_cnt++;
         if (flush) begin
            exp_q.delete();
         end else begin
            can_take = (exp_q.size() < 2);
            if (dn_ready && exp_q.size() != 0) void'(exp_q.pop_front());
            if (up_valid && can_take) exp_q.push_back(capture(up_pc, up_idata, up_lane_mask));
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("m_dn_valid", {159'd0, dn_valid}, {159'd0, exp_q.size() != 0});
         check("m_up_ready", {159'd0, up_ready}, {159'd0, exp_q.size() < 2});
         check("m_bubble_cnt", {156'd0, bubble_cnt}, IW'(exp_cnt));
         if (exp_q.size() != 0) begin
            check("m_dn_pc", {128'd0, dn_pc}, {128'd0, exp_q[0].pc});
            check("m_dn_idata", dn_idata, exp_q[0].idata);
            check("m_dn_mask", {155'd0, dn_lane_mask}, {155'd0, exp_q[0].mask});
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input logic v, input logic [XLEN-1:0] pc);
      up_valid     = v;
      up_pc        = pc;
      up_lane_mask = 5'b11111;
      for (int i = 0; i < LANES; i++) up_idata[i*ILEN +: ILEN] = $urandom;
   endtask

   logic [31:0] kill_exp [LANES];

   initial begin
      rst = 1'b1; flush = 1'b0; dn_ready = 1'b0;
      offer(1'b0, 32'h0);

      // reset
      step(); chk_en = 1'b1;
      step();
      check("rst_dn_valid", {159'd0, dn_valid}, 160'd0);
      check("rst_dn_pc", {128'd0, dn_pc}, 160'd0);
      check("rst_dn_idata", dn_idata, 160'd0);
      check("rst_dn_mask", {155'd0, dn_lane_mask}, 160'd0);
      check("rst_bubble", {156'd0, bubble_cnt}, 160'd0);
      rst = 1'b0;
      step();
      check("rst_up_ready", {159'd0, up_ready}, 160'd1);
      check("rst_still_empty", {159'd0, dn_valid}, 160'd0);

      // streaming
      dn_ready = 1'b1;
      offer(1'b1, 32'h100); step();
      check("stream_pc0", {128'd0, dn_pc}, 160'h100);
      check("stream_rdy0", {159'd0, up_ready}, 160'd1);
      offer(1'b1, 32'h114); step();
      check("stream_pc1", {128'd0, dn_pc}, 160'h114);
      offer(1'b1, 32'h128); step();
      check("stream_pc2", {128'd0, dn_pc}, 160'h128);
      check("stream_rdy2", {159'd0, up_ready}, 160'd1);
      offer(1'b0, 32'h0); step();
      check("stream_drain", {159'd0, dn_valid}, 160'd0);

      // backpressure
      dn_ready = 1'b0;
      offer(1'b1, 32'h100); step();
      check("bp_m_pc", {128'd0, dn_pc}, 160'h100);
      offer(1'b1, 32'h114); step();
      check("bp_s_full_rdy", {159'd0, up_ready}, 160'd0);
      check("bp_hold_pc", {128'd0, dn_pc}, 160'h100);
      offer(1'b1, 32'h128); step();
      check("bp_held_rdy", {159'd0, up_ready}, 160'd0);
      check("bp_held_pc", {128'd0, dn_pc}, 160'h100);
      dn_ready = 1'b1; step();
      check("bp_out1", {128'd0, dn_pc}, 160'h114);
      check("bp_rdy_back", {159'd0, up_ready}, 160'd1);
      step();
      check("bp_out2", {128'd0, dn_pc}, 160'h128);
      offer(1'b0, 32'h0); step();
      check("bp_drain", {159'd0, dn_valid}, 160'd0);

      // lane kill
      up_valid = 1'b1; up_pc = 32'h140; up_lane_mask = 5'b10101;
      for (int i = 0; i < LANES; i++) up_idata[i*ILEN +: ILEN] = 32'hAAAA0000 + i;
      kill_exp = '{32'hAAAA0000, 32'h00000013, 32'hAAAA0002, 32'h00000013, 32'hAAAA0004};
      step();
      for (int i = 0; i < LANES; i++)
         check($sformatf("kill_lane%0d", i), {128'd0, dn_idata[i*ILEN +: ILEN]}, {128'd0, kill_exp[i]});
      check("kill_mask", {155'd0, dn_lane_mask}, {155'd0, 5'b10101});
      offer(1'b0, 32'h0); step();

      // flush with both entries full
      dn_ready = 1'b0;
      offer(1'b1, 32'h300); step();
      offer(1'b1, 32'h314); step();
      check("fl_full", {159'd0, up_ready}, 160'd0);
      flush = 1'b1; offer(1'b1, 32'h200); step();
      check("fl_dn_valid", {159'd0, dn_valid}, 160'd0);
      check("fl_up_ready", {159'd0, up_ready}, 160'd1);
      flush = 1'b0; offer(1'b0, 32'h0); dn_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         check("fl_no_emit", {159'd0, dn_valid}, 160'd0);
      end

      // bubble counter saturation
      rst = 1'b1; step();
      check("cnt_rst", {156'd0, bubble_cnt}, 160'd0);
      rst = 1'b0;
      repeat ((1 << CNT_W) + 3) step();
      check("cnt_sat", {156'd0, bubble_cnt}, 160'd15);
      step();
      check("cnt_hold", {156'd0, bubble_cnt}, 160'd15);

      // randomized traffic against the model
      for (int k = 0; k < 3000; k++) begin
         rst          = ($urandom_range(0, 199) == 0);
         flush        = ($urandom_range(0, 31) == 0);
         up_valid     = ($urandom_range(0, 3) != 0);
         dn_ready     = ($urandom_range(0, 2) != 0);
         up_pc        = $urandom;
         up_lane_mask = LANES'($urandom);
         for (int i = 0; i < LANES; i++) up_idata[i*ILEN +: ILEN] = $urandom;
         step();
      end

      @(negedge clk);
      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
